par_mult: RTL and testbench
===========================

Name: par_mult

Overview:
- Pipelined unsigned 8x8 parallel array multiplier.
- Partial products are reduced with carry-save adder rows and a final ripple or carry-propagate adder.
- The product is truncated to 15 bits, and an overflow flag reports any lost MSB.
- Used as a datapath arithmetic primitive behind a simple valid-qualified stream interface.

Parameters:
- WIDTH, 8, operand width in bits. Supported range 4..16.
- PW, 2*WIDTH-1 (15), product output width. Fixed relation to WIDTH; not independently overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  a and b carry a valid operand pair this cycle.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  c and ovf are valid this cycle.
- c  output  PW  product bits [PW-1:0], i.e. (a*b) mod 2^PW.
- ovf  output  1  set when the full 2*WIDTH-bit product has bit 2*WIDTH-1 set (product >= 2^PW).

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline registers clear immediately; out_valid=0, c=0, ovf=0.
- Reset release is synchronous to clk. The first capture happens on the first rising edge with rst_n high.
- Stage 0, on every clk edge: register in_valid, a and b into the input stage.
- Stage 1, combinational:
  - Generate partial products pp[i] = a_r & {WIDTH{b_r[i]}}.
  - Reduce with WIDTH-2 carry-save rows of full/half adders.
  - Resolve with a final carry-propagate adder into a 2*WIDTH-bit full product.
- Stage 1 result is registered into c, ovf and out_valid on the next edge.
- Latency: 2 clk cycles from the in_valid/operand sample edge to the out_valid/result edge.
- Throughput: one result per cycle; no backpressure, no stall input.
- Invalid beats: operands are still registered, but c and ovf hold their previous value; out_valid=0 for that slot.
- Arithmetic:
  - Strictly unsigned. c = full[PW-1:0]; ovf = full[2*WIDTH-1].
  - No saturation: c wraps modulo 2^PW.
- Boundaries:
  - a=0 or b=0 gives c=0, ovf=0.
  - a=b=2^WIDTH-1 gives maximum product, with wrap and ovf=1.
  - Back-to-back valid beats each produce an independent result, with no inter-beat interference.
- Reset mid-operation: in-flight beats are discarded; out_valid stays 0 until a fresh beat traverses the full latency.
- The combinational array must be a structural adder array (generate loops), not a behavioural '*' operator.

Optional Feature:
- Macro: PARMULT_PIPE_EN.
- Defined:
  - An extra register stage splits the carry-save array after row WIDTH/2 (sums, carries, remaining partial products and valid).
  - Latency becomes 3 cycles; throughput is unchanged at one per cycle.
  - Reset clears the extra stage too.
- Undefined: 2-cycle latency as above, with no mid-array register.

Test Plan:
- Reset: hold rst_n=0 with random a/b and in_valid=1 -> out_valid=0, c=0, ovf=0 throughout; assertion mid-stream clears out_valid within the same cycle.
- Small/mid operands, valid stream:
  - a=0x08, b=0x08 -> c=64, ovf=0.
  - a=0x13, b=0x37 -> c=1045, ovf=0.
  - a=0x2C, b=0x6A -> c=4664, ovf=0.
  - a=0xDA, b=0x56 -> c=18748, ovf=0.
  - Each result arrives 2 cycles after its input (3 with PARMULT_PIPE_EN).
- Overflow/wrap:
  - a=0xFF, b=0xFF -> c=32257, ovf=1.
  - a=0xFB, b=0xBE -> c=14922, ovf=1.
  - a=0xF4, b=0x9C -> c=5296, ovf=1.
  - a=0xDF, b=0xBA -> c=8710, ovf=1.
  - a=0x99, b=0xFD -> c=5941, ovf=1.
- Back-to-back: all nine pairs above on consecutive cycles with in_valid=1 -> nine consecutive out_valid pulses with matching results, in order.
- Gaps: alternate in_valid 1/0 with changing operands -> out_valid follows the pattern delayed by the latency; c holds its previous value in gap slots.
- Zero/identity: a=0x00, b=0xFF -> c=0, ovf=0; a=0x01, b=0xAB -> c=171, ovf=0.

Source files
------------

// File: rtl/par_mult.sv
// par_mult: pipelined unsigned WIDTH x WIDTH carry-save array multiplier, (2*WIDTH-1)-bit product plus overflow.
// Define PARMULT_PIPE_EN to register the array midway (latency 3 instead of 2).
module par_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [2*WIDTH-2:0] c,
  output logic               ovf
);
  localparam int PW = 2*WIDTH-1;
  localparam int FW = 2*WIDTH;
  localparam int NR = WIDTH-2;
  logic [WIDTH-1:0] a_r, b_r;
  logic v_r, fin_v;
  logic [FW-1:0] ppx [WIDTH];
  logic [FW-1:0] ppz [2:WIDTH-1];
  logic [FW-1:0] sx [NR+1];
  logic [FW-1:0] sy [NR+1];
  logic [FW-1:0] px [NR+1];
  logic [FW-1:0] py [NR+1];
  logic [FW-1:0] full;
  logic [FW-1:0] cc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      v_r <= 1'b0;
    end else begin
      a_r <= a;
      b_r <= b;
      v_r <= in_valid;
    end
  genvar i, k;
  for (i = 0; i < WIDTH; i++) begin : g_pp
    assign ppx[i] = FW'(a_r & {WIDTH{b_r[i]}}) << i;
  end
  assign sx[0] = ppx[0];
  assign sy[0] = ppx[1];
  // each row folds one more partial product into the (sum, carry) pair
  for (i = 0; i < NR; i++) begin : g_row
    logic [FW-1:0] s;
    logic [FW-2:0] cy;
    for (k = 0; k < FW; k++) begin : g_fa
      assign s[k] = px[i][k] ^ py[i][k] ^ ppz[i+2][k];
      if (k < FW-1) begin : g_cy
        assign cy[k] = (px[i][k] & py[i][k]) | (ppz[i+2][k] & (px[i][k] ^ py[i][k]));
      end
    end
    assign sx[i+1] = s;
    assign sy[i+1] = {cy, 1'b0};
  end
`ifdef PARMULT_PIPE_EN
  localparam int SPLIT = WIDTH/2;
  logic [FW-1:0] s_m, c_m;
  logic [FW-1:0] ppm [2:WIDTH-1];
  logic v_m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_m <= '0;
      c_m <= '0;
      v_m <= 1'b0;
      for (int j = 2; j < WIDTH; j++) ppm[j] <= '0;
    end else begin
      s_m <= sx[SPLIT];
      c_m <= sy[SPLIT];
      v_m <= v_r;
      for (int j = 2; j < WIDTH; j++) ppm[j] <= ppx[j];
    end
  for (i = 0; i <= NR; i++) begin : g_sel
    assign px[i] = (i == SPLIT) ? s_m : sx[i];
    assign py[i] = (i == SPLIT) ? c_m : sy[i];
  end
  for (i = 2; i < WIDTH; i++) begin : g_ppz
    assign ppz[i] = (i < SPLIT+2) ? ppx[i] : ppm[i];
  end
  assign fin_v = v_m;
`else
  for (i = 0; i <= NR; i++) begin : g_sel
    assign px[i] = sx[i];
    assign py[i] = sy[i];
  end
  for (i = 2; i < WIDTH; i++) begin : g_ppz
    assign ppz[i] = ppx[i];
  end
  assign fin_v = v_r;
`endif
  assign cc[0] = 1'b0;
  for (k = 0; k < FW; k++) begin : g_cpa
    assign full[k] = px[NR][k] ^ py[NR][k] ^ cc[k];
    if (k < FW-1) begin : g_c
      assign cc[k+1] = (px[NR][k] & py[NR][k]) | (cc[k] & (px[NR][k] ^ py[NR][k]));
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      c         <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= fin_v;
      if (fin_v) begin
        c   <= full[PW-1:0];
        ovf <= full[FW-1];
      end
    end
endmodule

// File: tb/tb_par_mult.sv
// tb_par_mult: directed-vector bench for par_mult with a latency-delayed expectation pipe.
module tb_par_mult;
  localparam int W  = 8;
  localparam int PW = 15;
`ifdef PARMULT_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int NV = 11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic out_valid;
  logic [PW-1:0] c;
  logic ovf;
  par_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .c(c), .ovf(ovf)
  );
  always #5 clk = ~clk;
  logic [W-1:0]  va [NV] = '{8'h08, 8'h13, 8'h2C, 8'hDA, 8'hFF, 8'hFB, 8'hF4, 8'hDF, 8'h99, 8'h00, 8'h01};
  logic [W-1:0]  vb [NV] = '{8'h08, 8'h37, 8'h6A, 8'h56, 8'hFF, 8'hBE, 8'h9C, 8'hBA, 8'hFD, 8'hFF, 8'hAB};
  logic [PW-1:0] vc [NV] = '{15'd64, 15'd1045, 15'd4664, 15'd18748, 15'd32257, 15'd14922,
                             15'd5296, 15'd8710, 15'd5941, 15'd0, 15'd171};
  logic          vo [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  int n_chk = 0;
  int n_fail = 0;
  logic          hv [LAT];
  logic [PW-1:0] hc [LAT];
  logic          ho [LAT];
  logic [PW-1:0] mc;
  logic          mo;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clear_model();
    for (int i = 0; i < LAT; i++) begin
      hv[i] = 1'b0;
      hc[i] = '0;
      ho[i] = 1'b0;
    end
    mc = '0;
    mo = 1'b0;
  endtask
  task automatic step(input string tag, input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [PW-1:0] ec, input logic eo);
    in_valid = v;
    a = ia;
    b = ib;
    @(posedge clk);
    for (int i = LAT-1; i > 0; i--) begin
      hv[i] = hv[i-1];
      hc[i] = hc[i-1];
      ho[i] = ho[i-1];
    end
    hv[0] = v;
    hc[0] = ec;
    ho[0] = eo;
    if (hv[LAT-1]) begin
      mc = hc[LAT-1];
      mo = ho[LAT-1];
    end
    #1;
    check({tag, ".valid"}, 32'(out_valid), 32'(hv[LAT-1]));
    check({tag, ".c"}, 32'(c), 32'(mc));
    check({tag, ".ovf"}, 32'(ovf), 32'(mo));
    @(negedge clk);
  endtask
  task automatic idle(input string tag);
    step(tag, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), '0, 1'b0);
  endtask
  task automatic vec(input string tag, input logic v, input int n);
    step(tag, v, va[n], vb[n], vc[n], vo[n]);
  endtask
  initial begin
    clear_model();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check("rst_hold.valid", 32'(out_valid), 32'd0);
      check("rst_hold.c", 32'(c), 32'd0);
      check("rst_hold.ovf", 32'(ovf), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int n = 0; n < NV; n++) begin
      vec($sformatf("single%0d", n), 1'b1, n);
      for (int j = 0; j < LAT; j++) idle($sformatf("single%0d_flush", n));
    end
    for (int n = 0; n < 9; n++) vec($sformatf("b2b%0d", n), 1'b1, n);
    for (int j = 0; j < LAT; j++) idle("b2b_flush");
    for (int n = 0; n < NV; n++) vec($sformatf("gap%0d", n), (n % 2) == 0, n);
    for (int j = 0; j < LAT; j++) idle("gap_flush");
    for (int n = 4; n < 8; n++) vec($sformatf("pre_rst%0d", n), 1'b1, n);
    rst_n = 1'b0;
    #1;
    check("mid_rst.valid", 32'(out_valid), 32'd0);
    check("mid_rst.c", 32'(c), 32'd0);
    check("mid_rst.ovf", 32'(ovf), 32'd0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_edge.valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    for (int j = 0; j < LAT; j++) idle("post_rst_idle");
    vec("post_rst_beat", 1'b1, 5);
    for (int j = 0; j < LAT; j++) idle("post_rst_flush");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
